// File: rtl/flow_fifo_hash_if.sv
// Handshake/bus bundle for flow_fifo_hash: FIFO write/read port plus hash tuple and indices.
`timescale 1ns/1ps
interface flow_fifo_hash_if #(
  parameter int unsigned WIDTH        = 72,
  parameter int unsigned INPUT_WIDTH  = 96,
  parameter int unsigned OUTPUT_WIDTH = 19
);
  logic [WIDTH-1:0]        din;
  logic                    wr_en;
  logic                    rd_en;
  logic [WIDTH-1:0]        dout;
  logic                    full;
  logic                    nearly_full;
  logic                    empty;
  logic [INPUT_WIDTH-1:0]  data;
  logic [OUTPUT_WIDTH-1:0] hash_0;
  logic [OUTPUT_WIDTH-1:0] hash_1;

  modport slave (
    input  din, wr_en, rd_en, data,
    output dout, full, nearly_full, empty, hash_0, hash_1
  );

  modport master (
    output din, wr_en, rd_en, data,
    input  dout, full, nearly_full, empty, hash_0, hash_1
  );
endinterface

// File: rtl/flow_fifo_hash.sv
// Ingress helper: fall-through packet FIFO plus a registered dual-index XOR-fold flow hash.
`timescale 1ns/1ps
module flow_fifo_hash #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3,
  parameter int unsigned NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1,
  parameter int unsigned INPUT_WIDTH    = 96,
  parameter int unsigned OUTPUT_WIDTH   = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  flow_fifo_hash_if.slave        io_bus
);

  localparam int unsigned DEPTH  = 2**MAX_DEPTH_BITS;
  localparam int unsigned NCHUNK = (INPUT_WIDTH + OUTPUT_WIDTH - 1) / OUTPUT_WIDTH;
  localparam int unsigned PADW   = NCHUNK * OUTPUT_WIDTH;
  localparam int unsigned CW     = MAX_DEPTH_BITS + 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] PTR_LAST_C = CW'(DEPTH - 1);
  localparam logic [CW-1:0] NF_C       = CW'(NEARLY_FULL);

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_wr_ptr_d;
  logic [CW-1:0]    w_rd_ptr_d;
  logic [CW-1:0]    w_count_d;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign w_push  = io_bus.wr_en && !w_full;
  assign w_pop   = io_bus.rd_en && !w_empty;

  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    if (w_push) begin
      w_wr_ptr_d = (r_wr_ptr == PTR_LAST_C) ? '0 : r_wr_ptr + 1'b1;
    end
    if (w_pop) begin
      w_rd_ptr_d = (r_rd_ptr == PTR_LAST_C) ? '0 : r_rd_ptr + 1'b1;
    end
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr[MAX_DEPTH_BITS-1:0]] <= io_bus.din;
    end
  end

  assign io_bus.dout        = r_mem[r_rd_ptr[MAX_DEPTH_BITS-1:0]];
  assign io_bus.empty       = w_empty;
  assign io_bus.full        = w_full;
  assign io_bus.nearly_full = (r_count >= NF_C);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (io_bus.wr_en && w_full) begin
        $display("flow_fifo_hash: write while full dropped at %0t", $time);
      end
      if (io_bus.rd_en && w_empty) begin
        $display("flow_fifo_hash: read while empty ignored at %0t", $time);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Hash: XOR-fold of the tuple and of its bit-reversed image, last chunk zero-padded
  // ---------------------------------------------------------------------------
  logic [PADW-1:0]         w_pad;
  logic [PADW-1:0]         w_rev_pad;
  logic [OUTPUT_WIDTH-1:0] w_fold_0;
  logic [OUTPUT_WIDTH-1:0] w_fold_1;
  logic [OUTPUT_WIDTH-1:0] r_hash_0;
  logic [OUTPUT_WIDTH-1:0] r_hash_1;

  always_comb begin
    w_pad     = '0;
    w_rev_pad = '0;
    w_fold_0  = '0;
    w_fold_1  = '0;
    w_pad[INPUT_WIDTH-1:0] = io_bus.data;
    for (int i = 0; i < int'(INPUT_WIDTH); i++) begin
      w_rev_pad[i] = io_bus.data[int'(INPUT_WIDTH) - 1 - i];
    end
    for (int k = 0; k < int'(NCHUNK); k++) begin
      w_fold_0 = w_fold_0 ^ w_pad[k*int'(OUTPUT_WIDTH) +: OUTPUT_WIDTH];
      w_fold_1 = w_fold_1 ^ w_rev_pad[k*int'(OUTPUT_WIDTH) +: OUTPUT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hash_0 <= '0;
      r_hash_1 <= '0;
    end else begin
      r_hash_0 <= w_fold_0;
      r_hash_1 <= w_fold_1;
    end
  end

  assign io_bus.hash_0 = r_hash_0;
  assign io_bus.hash_1 = r_hash_1;

endmodule

// File: tb/tb_flow_fifo_hash.sv
// Self-checking bench for flow_fifo_hash: queue/arithmetic model compared every cycle plus
// hand-computed literal checks on directed vectors.
`timescale 1ns/1ps
module tb_flow_fifo_hash;

  logic clk;
  logic reset;

  flow_fifo_hash_if #(.WIDTH(72), .INPUT_WIDTH(96), .OUTPUT_WIDTH(19)) bus ();

  flow_fifo_hash #(
    .WIDTH(72), .MAX_DEPTH_BITS(3), .NEARLY_FULL(7), .INPUT_WIDTH(96), .OUTPUT_WIDTH(19)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  bit          chk_en  = 1'b0;

  logic [71:0] m_q [$];
  logic [18:0] m_h0;
  logic [18:0] m_h1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output bit j is the parity of every input bit whose index is congruent to j mod 19.
  function automatic logic [18:0] fold(input logic [95:0] d);
    logic [18:0] h = '0;
    for (int i = 0; i < 96; i++) h[i % 19] = h[i % 19] ^ d[i];
    return h;
  endfunction

  function automatic logic [95:0] rev(input logic [95:0] d);
    logic [95:0] r;
    for (int i = 0; i < 96; i++) r[i] = d[95 - i];
    return r;
  endfunction

  // Reference model, advanced on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_h0 = '0;
      m_h1 = '0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = bus.wr_en && (m_q.size() < 8);
      do_pop  = bus.rd_en && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(bus.din);
      m_h0 = fold(bus.data);
      m_h1 = fold(rev(bus.data));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_empty", 96'(bus.empty), 96'(m_q.size() == 0));
      check("m_full", 96'(bus.full), 96'(m_q.size() == 8));
      check("m_nearly_full", 96'(bus.nearly_full), 96'(m_q.size() >= 7));
      if (m_q.size() > 0) check("m_dout", 96'(bus.dout), 96'(m_q[0]));
      check("m_hash_0", 96'(bus.hash_0), 96'(m_h0));
      check("m_hash_1", 96'(bus.hash_1), 96'(m_h1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    bus.din   = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.data  = '0;
    tick();
    tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    tick();
    check("rst_empty", 96'(bus.empty), 96'd1);
    check("rst_full", 96'(bus.full), 96'd0);
    check("rst_nf", 96'(bus.nearly_full), 96'd0);
    check("rst_h0", 96'(bus.hash_0), 96'd0);
    check("rst_h1", 96'(bus.hash_1), 96'd0);

    // Fill to full, then one dropped write.
    bus.wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.din = 72'(i);
      tick();
      if (i == 6) check("nf_after6", 96'(bus.nearly_full), 96'd0);
      if (i == 7) begin
        check("nf_after7", 96'(bus.nearly_full), 96'd1);
        check("full_after7", 96'(bus.full), 96'd0);
      end
    end
    check("full_after8", 96'(bus.full), 96'd1);
    bus.din = 72'hFF;
    tick();
    bus.wr_en = 1'b0;
    check("full_after_drop", 96'(bus.full), 96'd1);

    // Drain: order 1..8, then empty; an extra read stays empty.
    bus.rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_dout", 96'(bus.dout), 96'(i));
      tick();
    end
    check("drain_empty", 96'(bus.empty), 96'd1);
    tick();
    check("extra_rd_empty", 96'(bus.empty), 96'd1);
    bus.rd_en = 1'b0;

    // Occupancy 4, then 20 cycles of simultaneous write/read across pointer wrap.
    bus.wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.din = 72'(8'h10 + i);
      tick();
    end
    bus.rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.din = 72'(8'h14 + k);
      check("stream_dout", 96'(bus.dout), 96'(8'h10 + k));
      check("stream_full", 96'(bus.full), 96'd0);
      check("stream_empty", 96'(bus.empty), 96'd0);
      tick();
    end
    bus.wr_en = 1'b0;
    for (int k = 20; k < 24; k++) begin
      check("stream_tail", 96'(bus.dout), 96'(8'h10 + k));
      tick();
    end
    bus.rd_en = 1'b0;
    check("stream_drained", 96'(bus.empty), 96'd1);

    // Single word: visible right after the write edge, gone right after the pop edge.
    bus.din   = 72'hAB;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("single_empty", 96'(bus.empty), 96'd0);
    check("single_dout", 96'(bus.dout), 96'hAB);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("single_popped", 96'(bus.empty), 96'd1);

    // Hash vectors, each one cycle after presentation.
    bus.data = 96'h2;
    tick();
    check("h0_two", 96'(bus.hash_0), 96'h00002);
    check("h1_two", 96'(bus.hash_1), 96'h40000);
    bus.data = 96'h1;
    tick();
    check("h0_one", 96'(bus.hash_0), 96'h00001);
    check("h1_one", 96'(bus.hash_1), 96'h00001);
    bus.data = '1;
    tick();
    check("h0_ones", 96'(bus.hash_0), 96'h7FFFE);
    check("h1_ones", 96'(bus.hash_1), 96'h7FFFE);
    bus.data = 96'h0;
    tick();
    check("h0_zero", 96'(bus.hash_0), 96'h0);
    check("h1_zero", 96'(bus.hash_1), 96'h0);

    // Reset with 5 words stored; a write held during reset is ignored.
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.din = 72'(8'h21 + i);
      tick();
    end
    bus.din = 72'h99;
    reset   = 1'b1;
    tick();
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    check("midrst_empty", 96'(bus.empty), 96'd1);
    check("midrst_full", 96'(bus.full), 96'd0);
    bus.din   = 72'h31;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("postrst_dout", 96'(bus.dout), 96'h31);
    check("postrst_empty", 96'(bus.empty), 96'd0);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
